// File: rtl/instr_fetch_if.sv
// Bus between the Mipu fetch stage and its environment (control, instruction memory, decode).
// The master modport is the fetch stage itself.
interface instr_fetch_if;
    logic        start;
    logic [7:0]  start_addr;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [7:0]  im_addr;
    logic [15:0] im_data;
    logic [15:0] id_ir;
    logic [7:0]  id_pc;
    logic        id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    modport master (
        input  start, start_addr, stall, branch_taken, branch_target, im_data,
        output im_addr, id_ir, id_pc, id_valid, halted, fetch_count
    );

    modport slave (
        output start, start_addr, stall, branch_taken, branch_target, im_data,
        input  im_addr, id_ir, id_pc, id_valid, halted, fetch_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Mipu instruction-fetch stage: owns the PC, registers the IF/ID instruction word,
// and handles stall, branch redirect/flush and HALT detection.
module instr_fetch #(
    parameter logic [4:0]  HALT_OP  = 5'b00001,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic          clock,
    input  logic          reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  pc, pc_nxt;
    logic [15:0] ir, ir_nxt;
    logic [7:0]  ipc, ipc_nxt;
    logic        vld, vld_nxt;
    logic        hlt, hlt_nxt;
    logic [15:0] cnt, cnt_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        ipc_nxt   = ipc;
        vld_nxt   = vld;
        hlt_nxt   = hlt;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    pc_nxt    = bus.start_addr;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // Redirect beats stall: the word on im_data is wrong-path and must be dropped.
                if (bus.branch_taken) begin
                    pc_nxt  = bus.branch_target;
                    ir_nxt  = NOP_WORD;
                    vld_nxt = 1'b0;
                end else if (!bus.stall) begin
                    ir_nxt  = bus.im_data;
                    ipc_nxt = pc + 8'd1;
                    vld_nxt = 1'b1;
                    cnt_nxt = sat_inc(cnt);
                    if (bus.im_data[15:11] == HALT_OP) begin
                        state_nxt = HALTED;
                        hlt_nxt   = 1'b1;
                    end else begin
                        pc_nxt = pc + 8'd1;
                    end
                end
            end
            HALTED: begin
                // HALT word was shown for one cycle; from here on decode sees bubbles.
                ir_nxt  = NOP_WORD;
                vld_nxt = 1'b0;
                if (bus.branch_taken) begin
                    pc_nxt    = bus.branch_target;
                    hlt_nxt   = 1'b0;
                    state_nxt = RUN;
                end else if (bus.start) begin
                    pc_nxt    = bus.start_addr;
                    hlt_nxt   = 1'b0;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc  <= 8'd0;
            ir  <= NOP_WORD;
            ipc <= 8'd0;
            vld <= 1'b0;
            hlt <= 1'b0;
            cnt <= 16'd0;
        end else begin
            pc  <= pc_nxt;
            ir  <= ir_nxt;
            ipc <= ipc_nxt;
            vld <= vld_nxt;
            hlt <= hlt_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign bus.im_addr     = pc;
    assign bus.id_ir       = ir;
    assign bus.id_pc       = ipc;
    assign bus.id_valid    = vld;
    assign bus.halted      = hlt;
    assign bus.fetch_count = cnt;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the 16-bit Mipu CPU. It owns the 8-bit program counter, drives the address into the combinational instruction memory, registers the returned 16-bit word into the IF/ID instruction register, and handles stall, branch redirect/flush and HALT detection. It sits between the instruction memory and the decode stage and is the only reader of the instruction memory.

## Interface
Parameters:
- HALT_OP, 5'b00001, opcode value (instruction bits [15:11]) that stops fetch.
- NOP_WORD, 16'h0000, instruction word inserted on reset, flush and while halted.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse; leaves IDLE or HALTED and begins fetching at start_addr.
- start_addr  in  8  first fetch address, sampled on start.
- stall  in  1  hold request from downstream (hazard); freezes PC and IF/ID.
- branch_taken  in  1  redirect request from execute stage.
- branch_target  in  8  redirect address.
- im_addr  out  8  instruction-memory address; combinationally equal to pc.
- im_data  in  16  instruction word returned by memory in the same cycle.
- id_ir  out  16  registered instruction to decode.
- id_pc  out  8  registered address of the instruction in id_ir, plus 1.
- id_valid  out  1  id_ir holds a real fetched instruction.
- halted  out  1  high while in HALTED.
- fetch_count  out  16  number of instructions delivered with id_valid=1, saturating at 16'hFFFF.

## Operation
- States: IDLE, RUN, HALTED.
- Reset sets state=IDLE, pc=0, id_ir=NOP_WORD, id_pc=0, id_valid=0, halted=0, fetch_count=0.
- IDLE: pc holds, and id_ir/id_valid stay at NOP/0. A start pulse loads pc<=start_addr and moves to RUN.
- RUN, per edge, in priority order:
  1. branch_taken: pc<=branch_target, id_ir<=NOP_WORD, id_valid<=0. This flushes the wrong-path word and overrides stall.
  2. stall: pc, id_ir, id_pc, id_valid and fetch_count all hold.
  3. Otherwise: id_ir<=im_data, id_pc<=pc+1, id_valid<=1, fetch_count+=1 with saturation.
     - If im_data[15:11]==HALT_OP: pc holds, state<=HALTED, halted<=1.
     - Else: pc<=pc+1, with 8-bit wrap from 8'hFF to 8'h00.
- HALTED:
  - The first edge after entry loads id_ir<=NOP_WORD and id_valid<=0, so the HALT word is presented exactly once.
  - pc holds.
  - branch_taken (an older branch squashing a speculatively fetched HALT): pc<=branch_target, halted<=0, state<=RUN, id_ir stays NOP.
  - start: pc<=start_addr, halted<=0, state<=RUN.
  - branch_taken and start in the same cycle: branch_taken wins.
- start while in RUN is ignored.
- A stall in the cycle that would fetch HALT delays HALT detection until the stall drops.
- fetch_count increments only on edges where id_valid is loaded with 1.

## Timing
- Fetch latency is one cycle. im_addr=pc during cycle n, and that word appears on id_ir after edge n.
- Branch asserted in cycle n: im_addr=branch_target in cycle n+1, and the target instruction is on id_ir after edge n+1. Exactly one bubble is inserted.
- start in cycle n: first instruction is on id_ir after edge n+1.
- Asynchronous reset mid-operation returns every output to its reset value without waiting for a clock edge. Fetch resumes only after a new start.
- All outputs except im_addr are registered. im_addr has no combinational path from any input.

## Test plan
- Reset, then start with start_addr=0, memory holding LOAD/ADD words at 0..3 and HALT at 4:
  - id_ir shows words 0..4 on consecutive cycles, with id_pc=1..5.
  - Then halted=1, id_ir=16'h0000, id_valid=0, and fetch_count=5.
- stall held high for 3 cycles while id_ir shows the word at address 2: id_ir, id_pc=3, im_addr=3 and fetch_count all hold for 3 cycles. Fetch resumes with the word at address 3.
- branch_taken=1, branch_target=8'h0B while pc=7:
  - The next id_ir is NOP with id_valid=0.
  - The following cycle id_ir equals the word at 0x0B and id_pc=8'h0C.
  - Asserting stall in the branch cycle does not block the redirect.
- HALT at address 7 followed by branch_taken to 8'h0B one cycle later: halted pulses for one cycle, state returns to RUN, and the word at 0x0B is delivered.
- start with start_addr=8'hFE and non-HALT words everywhere: im_addr sequence is FE, FF, 00, 01, confirming wrap.
- Assert reset asynchronously mid-RUN between clock edges: all outputs are at reset values before the next edge. A later start with start_addr=5 fetches from 5.
